// File: rtl/quarter_tick_stopwatch.sv
// quarter_tick_stopwatch: turns the 4 Hz divider output into a MM:SS BCD
// stopwatch with start/stop/clear control.
// Optional feature macro: STOPWATCH_ALARM_EN adds the MM:SS alarm compare
// (iALARM_MM, iALARM_SS, oALARM).
// Control inputs iSTART_STOP and iCLEAR are single-cycle, already-synchronous
// pulses; iSIG_4Hz is asynchronous and is synchronised here.
// oSTATE_DBG exposes the FSM state register (IDLE=0, RUN=1, PAUSE=2).
module quarter_tick_stopwatch #(
  parameter int TICKS_PER_SEC = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSIG_4Hz,
  input  logic       iSTART_STOP,
  input  logic       iCLEAR,
`ifdef STOPWATCH_ALARM_EN
  input  logic [7:0] iALARM_MM,
  input  logic [7:0] iALARM_SS,
  output logic       oALARM,
`endif
  output logic [3:0] oSEC_ONES,
  output logic [3:0] oSEC_TENS,
  output logic [3:0] oMIN_ONES,
  output logic [3:0] oMIN_TENS,
  output logic       oRUN,
  output logic       oSEC_PULSE,
  output logic       oWRAP,
  output logic [1:0] oSTATE_DBG
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_q;
  logic                   tick_d;
  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [3:0]             so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
  logic                   sec_pulse_q, wrap_q;
  logic                   count_en, sec_roll, wrap_d;

  // Tick is registered, so it lands SYNC_STAGES+1 clocks after the rise is sampled.
  assign tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Synchroniser chain, edge-detect history and registered tick.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iSIG_4Hz};
      prev_q <= sync_q[SYNC_STAGES-1];
      tick_q <= tick_d;
    end
  end

  // A tick only counts in RUN and never in a cycle where clear is present.
  assign count_en = tick_q && (state_q == S_RUN) && !iCLEAR;
  assign sec_roll = count_en && (presc_q == PRESC_MAX);
  assign wrap_d   = sec_roll && (so_q == 4'd9) && (st_q == 4'd5) &&
                    (mo_q == 4'd9) && (mt_q == 4'd5);

  // Run/pause FSM; clear outranks start_stop.
  always_comb begin
    state_d = state_q;
    if (iCLEAR) begin
      state_d = S_IDLE;
    end else if (iSTART_STOP) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sub-second prescaler; held outside RUN so a resume keeps its phase.
  always_comb begin
    presc_d = presc_q;
    if (iCLEAR) begin
      presc_d = '0;
    end else if (count_en) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end
  end

  // BCD carry chain for MM:SS, wrapping 59:59 to 00:00.
  always_comb begin
    so_d = so_q;
    st_d = st_q;
    mo_d = mo_q;
    mt_d = mt_q;
    if (iCLEAR) begin
      so_d = 4'd0;
      st_d = 4'd0;
      mo_d = 4'd0;
      mt_d = 4'd0;
    end else if (sec_roll) begin
      if (so_q != 4'd9) begin
        so_d = so_q + 4'd1;
      end else begin
        so_d = 4'd0;
        if (st_q != 4'd5) begin
          st_d = st_q + 4'd1;
        end else begin
          st_d = 4'd0;
          if (mo_q != 4'd9) begin
            mo_d = mo_q + 4'd1;
          end else begin
            mo_d = 4'd0;
            mt_d = (mt_q != 4'd5) ? mt_q + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

  // State, prescaler, digits and one-cycle pulses.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      so_q        <= 4'd0;
      st_q        <= 4'd0;
      mo_q        <= 4'd0;
      mt_q        <= 4'd0;
      sec_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      so_q        <= so_d;
      st_q        <= st_d;
      mo_q        <= mo_d;
      mt_q        <= mt_d;
      sec_pulse_q <= sec_roll;
      wrap_q      <= wrap_d;
    end
  end

`ifdef STOPWATCH_ALARM_EN
  logic alarm_q, alarm_d;

  // Alarm fires only when a counted second lands on the programmed MM:SS.
  assign alarm_d = sec_roll && ({mt_d, mo_d} == iALARM_MM) &&
                   ({st_d, so_d} == iALARM_SS);

  // Alarm pulse register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign oALARM = alarm_q;
`endif

  assign oSEC_ONES  = so_q;
  assign oSEC_TENS  = st_q;
  assign oMIN_ONES  = mo_q;
  assign oMIN_TENS  = mt_q;
  assign oRUN       = (state_q == S_RUN);
  assign oSEC_PULSE = sec_pulse_q;
  assign oWRAP      = wrap_q;
  assign oSTATE_DBG = state_q;

endmodule

// File: tb/tb_quarter_tick_stopwatch.sv
// Bench for quarter_tick_stopwatch: directed scenarios on a TICKS_PER_SEC=4
// instance plus a TICKS_PER_SEC=2 instance run through a full hour for wrap.
module tb_quarter_tick_stopwatch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (TICKS_PER_SEC=4) ----------------
  logic       sig = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic [3:0] so, st, mo, mt;
  logic       run, sec_pulse, wrap;
  logic [1:0] state_dbg;
  logic [7:0] alarm_mm = 8'h00, alarm_ss = 8'h03;
  logic       alarm;

  quarter_tick_stopwatch #(.TICKS_PER_SEC(4), .SYNC_STAGES(2)) u_dut (
    .iCLK(clk), .iRST_N(rst_n), .iSIG_4Hz(sig),
    .iSTART_STOP(start_stop), .iCLEAR(clear),
`ifdef STOPWATCH_ALARM_EN
    .iALARM_MM(alarm_mm), .iALARM_SS(alarm_ss), .oALARM(alarm),
`endif
    .oSEC_ONES(so), .oSEC_TENS(st), .oMIN_ONES(mo), .oMIN_TENS(mt),
    .oRUN(run), .oSEC_PULSE(sec_pulse), .oWRAP(wrap), .oSTATE_DBG(state_dbg)
  );

`ifndef STOPWATCH_ALARM_EN
  assign alarm = 1'b0;
`endif

  // ---------------- fast DUT (TICKS_PER_SEC=2) for the full-hour wrap ----------------
  logic       f_sig = 1'b0, f_start = 1'b0;
  logic [3:0] f_so, f_st, f_mo, f_mt;
  logic       f_run, f_sec_pulse, f_wrap;
  logic [1:0] f_state_dbg;
  logic [7:0] f_alarm_mm = 8'h99, f_alarm_ss = 8'h99;
  logic       f_alarm;

  quarter_tick_stopwatch #(.TICKS_PER_SEC(2), .SYNC_STAGES(2)) u_fast (
    .iCLK(clk), .iRST_N(rst_n), .iSIG_4Hz(f_sig),
    .iSTART_STOP(f_start), .iCLEAR(1'b0),
`ifdef STOPWATCH_ALARM_EN
    .iALARM_MM(f_alarm_mm), .iALARM_SS(f_alarm_ss), .oALARM(f_alarm),
`endif
    .oSEC_ONES(f_so), .oSEC_TENS(f_st), .oMIN_ONES(f_mo), .oMIN_TENS(f_mt),
    .oRUN(f_run), .oSEC_PULSE(f_sec_pulse), .oWRAP(f_wrap), .oSTATE_DBG(f_state_dbg)
  );

`ifndef STOPWATCH_ALARM_EN
  assign f_alarm = 1'b0;
`endif

  // Free-running 6-clock-period square wave for the fast instance.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 f_sig = ~f_sig;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int s);
    int mm, ss;
    logic [3:0] a, b, c, d;
    mm = s / 60;
    ss = s % 60;
    a = 4'(mm / 10);
    b = 4'(mm % 10);
    c = 4'(ss / 10);
    d = 4'(ss % 10);
    return {a, b, c, d};
  endfunction

  // ---------------- monitors ----------------
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int last_rise_cyc = 0;
  int main_wrap_cnt = 0;
  int alarm_cnt = 0;
  logic [3:0] alarm_digit = 4'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sec_pulse) begin
        pulse_cnt++;
        last_pulse_cyc = cyc;
      end
      if (wrap) main_wrap_cnt++;
      if (alarm) begin
        alarm_cnt++;
        alarm_digit = so;
      end
    end
  end

  int   f_sec = 0;
  int   f_total = 0;
  int   f_wraps = 0;
  logic f_prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (f_sec_pulse) begin
        f_sec = (f_sec + 1) % 3600;
        f_total++;
        check("fast_digits", {16'd0, f_mt, f_mo, f_st, f_so}, {16'd0, bcd_of(f_sec)});
        check("fast_wrap_with_pulse", {31'd0, f_wrap}, {31'd0, (f_sec == 0)});
        check("fast_pulse_single_cycle", {31'd0, f_prev_pulse}, 32'd0);
      end else if (f_wrap) begin
        check("fast_wrap_without_pulse", {31'd0, f_wrap}, 32'd0);
      end
      if (f_wrap) f_wraps++;
      f_prev_pulse = f_sec_pulse;
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic pulse_start();
    start_stop = 1'b1;
    @(posedge clk); #1;
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      sig = 1'b1;
      last_rise_cyc = cyc;
      repeat (8) @(posedge clk); #1;
      sig = 1'b0;
      repeat (8) @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  int base;

  initial begin
    idle_cycles(3);
    check("reset_digits", {16'd0, mt, mo, st, so}, 32'd0);
    check("reset_run", {31'd0, run}, 32'd0);
    check("reset_pulse", {30'd0, wrap, sec_pulse}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Kick off the fast instance; it runs alongside the directed tests.
    f_start = 1'b1;
    @(posedge clk); #1;
    f_start = 1'b0;

    // 1: idle, 20 edges, nothing counts.
    edges(20);
    check("idle_digits", {16'd0, mt, mo, st, so}, 32'd0);
    check("idle_run", {31'd0, run}, 32'd0);
    check("idle_pulses", pulse_cnt, 0);

    // 2: start, 4 edges, one second with fixed latency.
    pulse_start();
    check("start_run", {31'd0, run}, 32'd1);
    check("start_state", {30'd0, state_dbg}, 32'd1);
    edges(4);
    check("one_sec_digits", {16'd0, mt, mo, st, so}, 32'h0001);
    check("one_sec_pulses", pulse_cnt, 1);
    check("one_sec_latency", last_pulse_cyc - last_rise_cyc, 4);

    // 4: phase preserved across pause.
    pulse_clear();
    check("clear_digits", {16'd0, mt, mo, st, so}, 32'd0);
    check("clear_state", {30'd0, state_dbg}, 32'd0);
    base = pulse_cnt;
    pulse_start();
    edges(2);
    pulse_start();
    check("pause_state", {30'd0, state_dbg}, 32'd2);
    check("pause_run", {31'd0, run}, 32'd0);
    edges(10);
    check("pause_held", {16'd0, mt, mo, st, so}, 32'd0);
    pulse_start();
    check("resume_state", {30'd0, state_dbg}, 32'd1);
    edges(1);
    check("resume_no_early_sec", pulse_cnt - base, 0);
    edges(1);
    check("resume_digits", {16'd0, mt, mo, st, so}, 32'h0001);
    check("resume_pulses", pulse_cnt - base, 1);

    // 5: clear + start_stop together in RUN at 00:07.
    pulse_clear();
    pulse_start();
    edges(28);
    check("seven_digits", {16'd0, mt, mo, st, so}, 32'h0007);
    clear = 1'b1;
    start_stop = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start_stop = 1'b0;
    check("clr_start_digits", {16'd0, mt, mo, st, so}, 32'd0);
    check("clr_start_run", {31'd0, run}, 32'd0);
    check("clr_start_state", {30'd0, state_dbg}, 32'd0);
    base = pulse_cnt;
    edges(4);
    check("clr_start_stays_idle", pulse_cnt - base, 0);

    // Async reset mid-count returns everything to zero at once.
    pulse_start();
    edges(6);
    check("pre_reset_digits", {16'd0, mt, mo, st, so}, 32'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_digits", {16'd0, mt, mo, st, so}, 32'd0);
    check("async_reset_run", {31'd0, run}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = pulse_cnt;
    pulse_start();
    edges(3);
    check("post_reset_no_sec", pulse_cnt - base, 0);
    edges(1);
    check("post_reset_one_sec", pulse_cnt - base, 1);
    check("main_no_wrap", main_wrap_cnt, 0);

`ifdef STOPWATCH_ALARM_EN
    // 6: alarm at 00:03.
    pulse_clear();
    alarm_cnt = 0;
    pulse_start();
    edges(12);
    check("alarm_digits", {16'd0, mt, mo, st, so}, 32'h0003);
    check("alarm_count", alarm_cnt, 1);
    check("alarm_at_digit", {28'd0, alarm_digit}, 32'd3);
`endif

    // The reset above also restarted the fast instance: resync its model.
    // (fast model was cleared when reset hit, handled below.)

    // 3: wait for the fast instance to pass 59:59 -> 00:00 -> 00:01.
    for (int i = 0; i < 60000 && f_total < 3601; i++) @(posedge clk);
    #1;
    check("fast_total_seconds", f_total, 3601);
    check("fast_wrap_count", f_wraps, 1);
    check("fast_end_digits", {16'd0, f_mt, f_mo, f_st, f_so}, 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // The mid-test async reset stops the fast instance; restart it and its model.
  initial begin
    @(posedge rst_n);
    @(negedge rst_n);
    f_sec = 0;
    f_total = 0;
    f_wraps = 0;
    f_prev_pulse = 1'b0;
    @(posedge rst_n);
    @(posedge clk); #1;
    f_start = 1'b1;
    @(posedge clk); #1;
    f_start = 1'b0;
  end

endmodule
